exec_unit_mdu: RTL and testbench
================================

Name: exec_unit_mdu

Overview:
- Parametrised execution unit for the single-cycle MIPS datapath. Successor to the combined ALU/shifter result stage.
- Merges the ALU, the barrel shifter, a sequential shift-add multiplier and the Hi/Lo register pair behind one registered valid/ready interface.
- The funct/ctrl decode selects the operation and the output source (ALU, shifter, Hi or Lo).

Parameters:
- WIDTH, 32: operand, result and Hi/Lo width; must be >= 8 and a power of 2.
- SHW, $clog2(WIDTH): shift-amount bits taken from B.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operation request.
- in_ready, output, 1: unit can accept; high only in IDLE.
- A, input, WIDTH: operand A; also the shift target.
- B, input, WIDTH: operand B; B[SHW-1:0] is the shift amount.
- ctrl, input, 3: ALU op code. 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed); any other code gives result 0.
- funct, input, 6: 00 SLL, 02 SRL, 03 SRA, 10 MFHI, 12 MFLO, 19 MULTU; any other funct uses the ALU per ctrl.
- result, output, WIDTH: registered result.
- zero, output, 1: registered (result == 0).
- out_valid, output, 1: one-cycle pulse marking a new result/zero.

Behaviour:
- Reset (rst high at an edge): state=IDLE, result=0, zero=0, out_valid=0, Hi=0, Lo=0, multiplier counter=0.
- Reset wins over every simultaneous event. Reset mid-multiply abandons the operation: no out_valid, Hi/Lo=0.
- Accept: an edge with in_valid && in_ready. If in_valid is high while in_ready is low, it is ignored, not queued.
- Single-cycle ops (ALU, shifts, MFHI, MFLO):
  - Accepted at edge E0; result, zero and out_valid=1 are visible after E0.
  - out_valid returns to 0 after E1 unless another op is accepted at E1.
  - Back-to-back issue every cycle is allowed.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag or trap.
- SLT gives 1 if $signed(A) < $signed(B), else 0.
- Shifts:
  - SLL and SRL shift in zeros; SRA replicates A[WIDTH-1].
  - Only B[SHW-1:0] is used; upper bits of B are ignored.
- MULTU, unsigned WIDTH x WIDTH -> 2*WIDTH:
  - At accept edge E0: latch A and B, state IDLE->MUL, counter=0, in_ready drops.
  - Each MUL edge processes one multiplier bit (shift-add) and increments the counter.
  - At edge E_WIDTH: {Hi,Lo} = product, result = Lo, zero = (Lo==0), out_valid=1, state->IDLE.
  - Total latency is WIDTH edges after accept. in_ready is high again in the same cycle as out_valid.
- MFHI/MFLO can never observe a partial product, because they cannot be accepted while busy.
- States: IDLE; MUL; DIV (only with DIVU_EN).
  - IDLE->MUL on MULTU accept; MUL->IDLE when counter == WIDTH-1 at the edge.
  - DIV follows the same rules.
- Hi/Lo change only on MULTU/DIVU completion or reset.
- result and zero hold their last value when no op completes.

Optional Feature:
- Macro: EXEC_UNIT_DIVU_EN.
- When defined:
  - funct 1B = DIVU, an unsigned restoring divider, one quotient bit per edge, WIDTH edges, same handshake as MULTU.
  - On completion Lo=quotient, Hi=remainder, result=Lo.
  - Divide by zero: Lo = all ones, Hi = A, same latency, no trap.
- When undefined: funct 1B decodes as an ALU op per ctrl; the DIV state and divider logic are absent.

Test Plan (WIDTH=32):
1. Reset, then ADD A=5, B=7, ctrl=010, funct=20 -> result=12, zero=0, out_valid high exactly one cycle after the accept edge; result before the op is 0.
2. SUB A=9, B=9 -> result=0, zero=1. SLT A=FFFFFFFF, B=1 -> result=1. ctrl=011 -> result=0, zero=1. Issue back-to-back every cycle -> out_valid high continuously.
3. SRA A=80000000, B=4 -> F8000000. SRL same operands -> 08000000. SLL A=3, B=33 (amount 1) -> 6.
4. MULTU A=FFFFFFFF, B=2 -> in_ready low for 32 cycles, out_valid at the 32nd edge after accept with result=FFFFFFFE. Then MFHI -> 1 and MFLO -> FFFFFFFE.
5. MULTU in flight, in_valid with ADD at cycle 5 -> ignored, no extra out_valid. Second MULTU with rst at cycle 10 -> in_ready=1, out_valid never pulses, MFHI -> 0.
6. With EXEC_UNIT_DIVU_EN: DIVU 100/7 -> Lo=14, Hi=2 after 32 cycles. DIVU 100/0 -> Lo=FFFFFFFF, Hi=100. Without the macro, funct 1B with ctrl=010, A=1, B=1 -> result=2 next cycle.

Source files
------------

// File: rtl/exec_unit_mdu_if.sv
// Request/response bundle for exec_unit_mdu: operands and decode in, registered result out.
interface exec_unit_mdu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       ctrl;
    logic [5:0]       funct;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             out_valid;

    modport master (
        output in_valid, A, B, ctrl, funct,
        input  in_ready, result, zero, out_valid
    );

    modport slave (
        input  in_valid, A, B, ctrl, funct,
        output in_ready, result, zero, out_valid
    );
endinterface

// File: rtl/exec_unit_mdu.sv
// ALU + barrel shifter + sequential MULTU with Hi/Lo behind one valid/ready port.
// Define EXEC_UNIT_DIVU_EN to add the sequential restoring DIVU (funct 1B).
module exec_unit_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst,
    exec_unit_mdu_if.slave bus
);
`ifdef EXEC_UNIT_DIVU_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_t             r_state, w_state_nxt;
    logic [SHW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi, r_lo, r_result;
    logic               r_zero, r_out_valid;

    logic               w_accept, w_done, w_is_mul, w_is_long;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_alu, w_op_res;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt, w_step;

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.out_valid = r_out_valid;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_is_mul = (bus.funct == 6'h19);
    assign w_shamt  = bus.B[SHW-1:0];

    // Shift-add: r_prod = {partial hi, remaining multiplier bits}, one bit per edge.
    assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};

`ifdef EXEC_UNIT_DIVU_EN
    logic               w_is_div, w_div_ge;
    logic [WIDTH:0]     w_div_trial, w_div_diff;
    logic [2*WIDTH-1:0] w_div_nxt;

    // Restoring divide: r_prod = {remainder, dividend bits still to shift in}.
    // A zero divisor always "fits", giving all-ones quotient and remainder = A.
    assign w_is_div    = (bus.funct == 6'h1B);
    assign w_is_long   = w_is_mul || w_is_div;
    assign w_div_trial = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    assign w_div_ge    = (w_div_trial >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_trial - {1'b0, r_opnd};
    assign w_div_nxt   = w_div_ge ? {w_div_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1}
                                  : {w_div_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};
    assign w_step      = (r_state == S_DIV) ? w_div_nxt : w_mul_nxt;
`else
    assign w_is_long   = w_is_mul;
    assign w_step      = w_mul_nxt;
`endif

    always_comb begin
        w_alu = '0;
        case (bus.ctrl)
            3'b000:  w_alu = bus.A & bus.B;
            3'b001:  w_alu = bus.A | bus.B;
            3'b010:  w_alu = bus.A + bus.B;
            3'b110:  w_alu = bus.A - bus.B;
            3'b111:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_op_res = w_alu;
        case (bus.funct)
            6'h00:   w_op_res = bus.A << w_shamt;
            6'h02:   w_op_res = bus.A >> w_shamt;
            6'h03:   w_op_res = WIDTH'($signed(bus.A) >>> w_shamt);
            6'h10:   w_op_res = r_hi;
            6'h12:   w_op_res = r_lo;
            default: w_op_res = w_alu;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul) w_state_nxt = S_MUL;
`ifdef EXEC_UNIT_DIVU_EN
                else if (w_accept && w_is_div) w_state_nxt = S_DIV;
`endif
            end
            default: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_prod      <= '0;
            r_opnd      <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state != S_IDLE) begin
                r_prod <= w_step;
                r_cnt  <= r_cnt + 1'b1;
            end
            if (w_done) begin
                r_hi        <= w_step[2*WIDTH-1:WIDTH];
                r_lo        <= w_step[WIDTH-1:0];
                r_result    <= w_step[WIDTH-1:0];
                r_zero      <= (w_step[WIDTH-1:0] == '0);
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                if (w_is_long) begin
                    // MULTU consumes B from the LSB up; DIVU shifts A in from the MSB.
                    r_prod <= {{WIDTH{1'b0}}, (w_is_mul ? bus.B : bus.A)};
                    r_opnd <= w_is_mul ? bus.A : bus.B;
                    r_cnt  <= '0;
                end else begin
                    r_result    <= w_op_res;
                    r_zero      <= (w_op_res == '0);
                    r_out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_exec_unit_mdu.sv
// Directed self-checking bench for exec_unit_mdu at WIDTH=32.
module tb_exec_unit_mdu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exec_unit_mdu_if #(.WIDTH(32)) bus ();
    exec_unit_mdu #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present an op, take one edge, sample 1ns later; in_valid stays high.
    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] c, input logic [5:0] f);
        bus.A = a; bus.B = b; bus.ctrl = c; bus.funct = f; bus.in_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Waits (bounded) for out_valid after a long-op accept; checks latency and busy.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        logic busy_ok;
        lat = 0; busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, "_ready_at_done"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int pulses;
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.ctrl = '0; bus.funct = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", {31'b0, bus.zero}, 32'd0);
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_ready", {31'b0, bus.in_ready}, 32'd1);

        op(32'd5, 32'd7, 3'b010, 6'h20); bus.in_valid = 1'b0;
        chk("add_result", bus.result, 32'd12);
        chk("add_zero", {31'b0, bus.zero}, 32'd0);
        chk("add_valid", {31'b0, bus.out_valid}, 32'd1);
        tick();
        chk("add_valid_drop", {31'b0, bus.out_valid}, 32'd0);
        chk("add_hold", bus.result, 32'd12);

        // Back-to-back stream, out_valid must stay high.
        op(32'd9, 32'd9, 3'b110, 6'h20);
        chk("sub_result", bus.result, 32'd0);
        chk("sub_zero", {31'b0, bus.zero}, 32'd1);
        op(32'hFFFF_FFFF, 32'd1, 3'b111, 6'h20);
        chk("slt_neg", bus.result, 32'd1);
        chk("b2b_valid1", {31'b0, bus.out_valid}, 32'd1);
        op(32'd1, 32'hFFFF_FFFF, 3'b111, 6'h20);
        chk("slt_pos", bus.result, 32'd0);
        op(32'd4, 32'd5, 3'b011, 6'h20);
        chk("badctrl_result", bus.result, 32'd0);
        chk("badctrl_zero", {31'b0, bus.zero}, 32'd1);
        chk("b2b_valid2", {31'b0, bus.out_valid}, 32'd1);
        op(32'h0000_F0F0, 32'h0000_FF00, 3'b000, 6'h24);
        chk("and", bus.result, 32'h0000_F000);
        op(32'h0000_F0F0, 32'h0000_FF00, 3'b001, 6'h25);
        chk("or", bus.result, 32'h0000_FFF0);
        op(32'hFFFF_FFFF, 32'd1, 3'b010, 6'h21);
        chk("add_wrap", bus.result, 32'd0);
        chk("add_wrap_zero", {31'b0, bus.zero}, 32'd1);

        op(32'h8000_0000, 32'd4, 3'b010, 6'h03);
        chk("sra", bus.result, 32'hF800_0000);
        op(32'h8000_0000, 32'd4, 3'b010, 6'h02);
        chk("srl", bus.result, 32'h0800_0000);
        op(32'd3, 32'd33, 3'b010, 6'h00);
        chk("sll_mask", bus.result, 32'd6);
        chk("b2b_valid3", {31'b0, bus.out_valid}, 32'd1);

        // MULTU FFFFFFFF*2 = 1_FFFFFFFE
        op(32'hFFFF_FFFF, 32'd2, 3'b000, 6'h19); bus.in_valid = 1'b0;
        chk("mul_accept_valid", {31'b0, bus.out_valid}, 32'd0);
        wait_done("mul1", 32);
        chk("mul1_result", bus.result, 32'hFFFF_FFFE);
        chk("mul1_zero", {31'b0, bus.zero}, 32'd0);
        op(32'd0, 32'd0, 3'b000, 6'h10);
        chk("mfhi1", bus.result, 32'd1);
        op(32'd0, 32'd0, 3'b000, 6'h12); bus.in_valid = 1'b0;
        chk("mflo1", bus.result, 32'hFFFF_FFFE);

        // MULTU 0x10000*0x30001 = 0x3_0001_0000; an ADD offered while busy is dropped.
        op(32'h0001_0000, 32'h0003_0001, 3'b000, 6'h19); bus.in_valid = 1'b0;
        repeat (4) tick();
        op(32'd1, 32'd1, 3'b010, 6'h20); bus.in_valid = 1'b0;
        chk("busy_ignore_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("busy_ignore_ready", {31'b0, bus.in_ready}, 32'd0);
        wait_done("mul2", 27);
        chk("mul2_result", bus.result, 32'h0001_0000);
        tick();
        chk("mul2_single_pulse", {31'b0, bus.out_valid}, 32'd0);
        op(32'd0, 32'd0, 3'b000, 6'h10); bus.in_valid = 1'b0;
        chk("mfhi2", bus.result, 32'd3);

        // Reset abandons an in-flight MULTU.
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 6'h19); bus.in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mul_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_mul_valid", {31'b0, bus.out_valid}, 32'd0);
        pulses = 0;
        repeat (40) begin
            tick();
            if (bus.out_valid === 1'b1) pulses++;
        end
        chk("rst_mul_no_pulse", 32'(pulses), 32'd0);
        op(32'd0, 32'd0, 3'b000, 6'h10);
        chk("rst_mfhi", bus.result, 32'd0);
        op(32'd0, 32'd0, 3'b000, 6'h12); bus.in_valid = 1'b0;
        chk("rst_mflo", bus.result, 32'd0);

`ifdef EXEC_UNIT_DIVU_EN
        op(32'd100, 32'd7, 3'b010, 6'h1B); bus.in_valid = 1'b0;
        wait_done("div1", 32);
        chk("div1_lo", bus.result, 32'd14);
        op(32'd0, 32'd0, 3'b000, 6'h10); bus.in_valid = 1'b0;
        chk("div1_hi", bus.result, 32'd2);
        op(32'd100, 32'd0, 3'b010, 6'h1B); bus.in_valid = 1'b0;
        wait_done("div0", 32);
        chk("div0_lo", bus.result, 32'hFFFF_FFFF);
        op(32'd0, 32'd0, 3'b000, 6'h10); bus.in_valid = 1'b0;
        chk("div0_hi", bus.result, 32'd100);
`else
        op(32'd1, 32'd1, 3'b010, 6'h1B); bus.in_valid = 1'b0;
        chk("f1b_alu_result", bus.result, 32'd2);
        chk("f1b_alu_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("f1b_alu_ready", {31'b0, bus.in_ready}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
